// File: rtl/beat_sequencer.sv
// Configurable machine-cycle beat sequencer for the hardwired controller.
// Emits one-hot beat strobes on t3. The controller can shorten, lengthen
// or stop machine cycles. Free-run and single-step operation are supported.
module beat_sequencer #(
  parameter int NUM_BEATS  = 4,
  parameter int NORMAL_LEN = 2,
  parameter int CNT_W      = 16,
  localparam int IDX_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
  input  logic                 t3,
  input  logic                 clr,
  input  logic                 run,
  input  logic                 step,
  input  logic                 short,
  input  logic                 long,
  input  logic                 stop,
  output logic [NUM_BEATS-1:0] w,
  output logic [IDX_W-1:0]     beat_idx,
  output logic                 cycle_first,
  output logic                 cycle_last,
  output logic                 halted,
  output logic [CNT_W-1:0]     cycle_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Index of the hard-cap beat, and of the last beat of a normal-length cycle.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);
  localparam logic [IDX_W-1:0] NORM_IDX = IDX_W'(NORMAL_LEN - 1);

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     beat_idx_reg, beat_idx_next;
  logic [NUM_BEATS-1:0] w_reg, w_next;
  logic [CNT_W-1:0]     cycle_count_reg, cycle_count_next;
  logic                 stop_pend_reg, stop_pend_next;
  logic                 end_beat;

  // State register: clr wins over everything, including a cycle in flight.
  always_ff @(posedge t3) begin
    if (clr) begin
      state_reg       <= ST_IDLE;
      beat_idx_reg    <= '0;
      w_reg           <= '0;
      cycle_count_reg <= '0;
      stop_pend_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      beat_idx_reg    <= beat_idx_next;
      w_reg           <= w_next;
      cycle_count_reg <= cycle_count_next;
      stop_pend_reg   <= stop_pend_next;
    end
  end

  // Next-state logic.
  // The current beat ends the cycle on short, at the cap, or once the
  // normal length has been reached without a long request.
  always_comb begin
    end_beat = (state_reg == ST_BEAT) &&
               (short || (beat_idx_reg == LAST_IDX) ||
                ((beat_idx_reg >= NORM_IDX) && !long));

    state_next       = state_reg;
    beat_idx_next    = beat_idx_reg;
    cycle_count_next = cycle_count_reg;
    stop_pend_next   = stop_pend_reg;

    unique case (state_reg)
      ST_IDLE: begin
        beat_idx_next = '0;
        if (run || step) begin
          state_next = ST_BEAT;
        end
      end
      ST_BEAT: begin
        // step is deliberately ignored here and is not remembered.
        if (end_beat) begin
          cycle_count_next = cycle_count_reg + CNT_W'(1);
          beat_idx_next    = '0;
          stop_pend_next   = 1'b0;
          if (stop_pend_reg || stop) begin
            state_next = ST_HALT;
          end else if (run) begin
            state_next = ST_BEAT;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          // A mid-cycle stop is remembered, but the cycle always completes.
          stop_pend_next = stop_pend_reg | stop;
          beat_idx_next  = beat_idx_reg + IDX_W'(1);
        end
      end
      ST_HALT: begin
        // Only step releases HALT; run on its own keeps it parked.
        beat_idx_next = '0;
        if (step) begin
          state_next = ST_BEAT;
        end
      end
      default: begin
        state_next    = ST_IDLE;
        beat_idx_next = '0;
      end
    endcase
  end

  // Decode the registered beat strobe one bit at a time from the next state.
  for (genvar gi = 0; gi < NUM_BEATS; gi++) begin : g_w_decode
    assign w_next[gi] = (state_next == ST_BEAT) && (beat_idx_next == IDX_W'(gi));
  end

  // Output logic: cycle_last follows the live inputs; the others come from registers.
  always_comb begin
    w           = w_reg;
    beat_idx    = beat_idx_reg;
    cycle_count = cycle_count_reg;
    halted      = (state_reg == ST_HALT);
    cycle_first = (state_reg == ST_BEAT) && (beat_idx_reg == '0);
    cycle_last  = end_beat;
  end

endmodule

// File: tb/tb_beat_sequencer.sv
// Self-checking bench for beat_sequencer (NUM_BEATS=4, NORMAL_LEN=2, CNT_W=16).
// Each vector row gives one clock of inputs and the expected outputs.
// Each row produces one line of output.
module tb_beat_sequencer;

  logic        t3 = 1'b0;
  logic        clr, run, step, short, long, stop;
  logic [3:0]  w;
  logic [1:0]  beat_idx;
  logic        cycle_first, cycle_last, halted;
  logic [15:0] cycle_count;

  int tests_run = 0;
  int tests_failed = 0;

  beat_sequencer #(.NUM_BEATS(4), .NORMAL_LEN(2), .CNT_W(16)) dut (
    .t3(t3), .clr(clr), .run(run), .step(step), .short(short), .long(long),
    .stop(stop), .w(w), .beat_idx(beat_idx), .cycle_first(cycle_first),
    .cycle_last(cycle_last), .halted(halted), .cycle_count(cycle_count)
  );

  always #5 t3 = ~t3;

  typedef struct {
    logic        clr, run, step, sh, lg, st;
    logic        exp_last;   // cycle_last before the edge
    logic [3:0]  exp_w;      // after the edge
    logic        exp_halt;
    logic [15:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic [3:0]  w;
    logic        halt;
    logic [15:0] cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic void add(input logic c, input logic r, input logic s,
                              input logic sh, input logic lg, input logic st,
                              input logic last, input logic [3:0] ew,
                              input logic eh, input logic [15:0] ec);
    vec_t v;
    v.clr = c; v.run = r; v.step = s; v.sh = sh; v.lg = lg; v.st = st;
    v.exp_last = last; v.exp_w = ew; v.exp_halt = eh; v.exp_cnt = ec;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one row at the falling edge, check cycle_last, and queue the expected results.
  // After the rising edge, pop and compare the registered outputs.
  task automatic apply(input vec_t v, input int row);
    exp_t e;
    logic [1:0] eidx;
    @(negedge t3);
    clr = v.clr; run = v.run; step = v.step; short = v.sh; long = v.lg; stop = v.st;
    #1;
    chk("cycle_last", {31'd0, cycle_last}, {31'd0, v.exp_last});
    e.w = v.exp_w; e.halt = v.exp_halt; e.cnt = v.exp_cnt;
    sb.push_back(e);
    @(posedge t3);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      eidx = 2'd0;
      for (int b = 0; b < 4; b++) if (e.w[b]) eidx = 2'(b);
      chk("w", {28'd0, w}, {28'd0, e.w});
      chk("beat_idx", {30'd0, beat_idx}, {30'd0, eidx});
      chk("cycle_first", {31'd0, cycle_first}, {31'd0, (e.w == 4'b0001)});
      chk("halted", {31'd0, halted}, {31'd0, e.halt});
      chk("cycle_count", {16'd0, cycle_count}, {16'd0, e.cnt});
    end
    $display("[TB] row %0d: clr=%b run=%b step=%b sh=%b lg=%b st=%b -> w=%b idx=%0d halt=%b cnt=%0d",
             row, v.clr, v.run, v.step, v.sh, v.lg, v.st, w, beat_idx, halted, cycle_count);
  endtask

  initial begin
    int n;
    clr = 1'b1; run = 1'b0; step = 1'b0; short = 1'b0; long = 1'b0; stop = 1'b0;

    //   clr run stp sh lg st | last w       halt cnt
    // Free run at normal length.
    add(0, 1, 0, 0, 0, 0, 0, 4'b0001, 0, 16'd0);
    add(0, 1, 0, 0, 0, 0, 0, 4'b0010, 0, 16'd0);
    add(0, 1, 0, 0, 0, 0, 1, 4'b0001, 0, 16'd1);
    add(0, 1, 0, 0, 0, 0, 0, 4'b0010, 0, 16'd1);
    add(0, 1, 0, 0, 0, 0, 1, 4'b0001, 0, 16'd2);
    // short held: one-beat cycles.
    add(0, 1, 0, 1, 0, 0, 1, 4'b0001, 0, 16'd3);
    add(0, 1, 0, 1, 0, 0, 1, 4'b0001, 0, 16'd4);
    add(0, 1, 0, 1, 0, 0, 1, 4'b0001, 0, 16'd5);
    // long on beat 1 gives one extra beat.
    add(0, 1, 0, 0, 0, 0, 0, 4'b0010, 0, 16'd5);
    add(0, 1, 0, 0, 1, 0, 0, 4'b0100, 0, 16'd5);
    add(0, 1, 0, 0, 0, 0, 1, 4'b0001, 0, 16'd6);
    // long on beats 1-3 stops at the cap on beat 3.
    add(0, 1, 0, 0, 0, 0, 0, 4'b0010, 0, 16'd6);
    add(0, 1, 0, 0, 1, 0, 0, 4'b0100, 0, 16'd6);
    add(0, 1, 0, 0, 1, 0, 0, 4'b1000, 0, 16'd6);
    add(0, 1, 0, 0, 1, 0, 1, 4'b0001, 0, 16'd7);
    // stop on beat 0: the cycle completes, then the sequencer halts.
    add(0, 1, 0, 0, 0, 1, 0, 4'b0010, 0, 16'd7);
    add(0, 1, 0, 0, 0, 0, 1, 4'b0000, 1, 16'd8);
    for (int i = 0; i < 10; i++) add(0, 1, 0, 0, 0, 0, 0, 4'b0000, 1, 16'd8);
    add(0, 1, 1, 0, 0, 0, 0, 4'b0001, 0, 16'd8);
    add(0, 1, 0, 0, 0, 0, 0, 4'b0010, 0, 16'd8);
    add(0, 1, 0, 0, 0, 0, 1, 4'b0001, 0, 16'd9);
    // With run=0 the machine drops to IDLE. Single step runs one cycle.
    // A step during beat 0 is ignored.
    add(0, 0, 0, 0, 0, 0, 0, 4'b0010, 0, 16'd9);
    add(0, 0, 0, 0, 0, 0, 1, 4'b0000, 0, 16'd10);
    add(0, 0, 1, 0, 0, 0, 0, 4'b0001, 0, 16'd10);
    add(0, 0, 1, 0, 0, 0, 0, 4'b0010, 0, 16'd10);
    add(0, 0, 0, 0, 0, 0, 1, 4'b0000, 0, 16'd11);
    add(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 16'd11);
    // short has priority over long.
    add(0, 1, 0, 0, 0, 0, 0, 4'b0001, 0, 16'd11);
    add(0, 1, 0, 1, 1, 0, 1, 4'b0001, 0, 16'd12);
    // clr arrives on beat 2 of a long cycle with a stop pending.
    add(0, 1, 0, 0, 0, 1, 0, 4'b0010, 0, 16'd12);
    add(0, 1, 0, 0, 1, 0, 0, 4'b0100, 0, 16'd12);
    add(1, 1, 0, 0, 1, 0, 0, 4'b0000, 0, 16'd0);
    add(0, 1, 0, 0, 0, 0, 0, 4'b0001, 0, 16'd0);
    add(0, 1, 0, 0, 0, 0, 0, 4'b0010, 0, 16'd0);
    add(0, 1, 0, 0, 0, 0, 1, 4'b0001, 0, 16'd1);

    // Hold clr for two edges, then check the reset state.
    repeat (2) @(posedge t3);
    #1;
    chk("reset_w", {28'd0, w}, 32'd0);
    chk("reset_beat_idx", {30'd0, beat_idx}, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("reset_cycle_count", {16'd0, cycle_count}, 32'd0);
    chk("reset_cycle_first", {31'd0, cycle_first}, 32'd0);
    chk("reset_cycle_last", {31'd0, cycle_last}, 32'd0);

    n = 0;
    foreach (vecs[i]) begin
      apply(vecs[i], n);
      n++;
    end

    // Single-step cycle that carries a stop. It halts after the cycle.
    // run alone does not leave HALT. step runs one cycle, then the machine returns to IDLE.
    begin
      vec_t v;
      vecs.delete();
      add(0, 0, 0, 0, 0, 1, 0, 4'b0010, 0, 16'd1);
      add(0, 0, 0, 0, 0, 0, 1, 4'b0000, 1, 16'd2);
      add(0, 1, 0, 0, 0, 0, 0, 4'b0000, 1, 16'd2);
      add(0, 1, 0, 0, 0, 0, 0, 4'b0000, 1, 16'd2);
      add(0, 0, 1, 0, 0, 0, 0, 4'b0001, 0, 16'd2);
      add(0, 0, 0, 0, 0, 0, 0, 4'b0010, 0, 16'd2);
      add(0, 0, 0, 0, 0, 0, 1, 4'b0000, 0, 16'd3);
      while (vecs.size() > 0) begin
        v = vecs.pop_front();
        apply(v, n);
        n++;
      end
    end

    if (sb.size() != 0) chk("scoreboard_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
